// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter. It snoops the core write bus, queues bytes
// stored to the TX data register and sends them as 8N1 frames, LSB first.
module uart_tx_mmio #(
   parameter logic [31:0] pAddr   = 32'h0000_1000,
   parameter int unsigned pClkDiv = 217,
   parameter int unsigned pFifoAw = 4
) (
   input  logic        iwClk,
   input  logic        iwnRst,
   input  logic [31:0] iwWriteAddr,
   input  logic [31:0] iwWriteData,
   input  logic [3:0]  iwWstrb,
   output logic        owTx,
   output logic        owBusy,
   output logic        owFull,
   output logic        owOverflow
);

   localparam int unsigned lpDepth = 2 ** pFifoAw;
   localparam int unsigned lpCntW  = $clog2(pClkDiv);
   localparam logic [lpCntW-1:0]  lpCntMax = lpCntW'(pClkDiv - 1);
   localparam logic [pFifoAw:0]   lpFull   = (pFifoAw + 1)'(lpDepth);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // FIFO storage and bookkeeping
   logic [7:0]         r_mem [lpDepth];
   logic [pFifoAw-1:0] r_wptr;
   logic [pFifoAw-1:0] r_rptr;
   logic [pFifoAw:0]   r_count;
   logic               r_overflow;

   // Transmit FSM state
   state_e             r_state;
   state_e             w_state_next;
   logic [lpCntW-1:0]  r_bitcnt;
   logic [lpCntW-1:0]  w_bitcnt_next;
   logic [2:0]         r_bitidx;
   logic [2:0]         w_bitidx_next;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_next;
   logic               r_tx;
   logic               w_tx_next;

   logic w_push_req;
   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;
   logic w_bit_end;
   logic w_unused;

   // Only lane 0 and the word address matter; the rest is deliberately ignored.
   assign w_unused = ^{iwWriteData[31:8], iwWstrb[3:1], iwWriteAddr[1:0]};

   assign w_push_req = (iwWriteAddr[31:2] == pAddr[31:2]) && iwWstrb[0];
   assign w_full     = (r_count == lpFull);
   assign w_empty    = (r_count == '0);
   // Fullness uses the pre-edge count, so a pop on the same edge cannot save a push.
   assign w_push     = w_push_req && !w_full;
   assign w_bit_end  = (r_bitcnt == lpCntMax);

   // FIFO data array; no reset needed since occupancy is tracked by r_count.
   always_ff @(posedge iwClk) begin
      if (w_push) begin
         r_mem[r_wptr] <= iwWriteData[7:0];
      end
   end

   // FIFO pointers, occupancy count and sticky overflow flag.
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push_req && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Transmit FSM registers; owTx comes straight from r_tx.
   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         r_state  <= StIdle;
         r_bitcnt <= '0;
         r_bitidx <= '0;
         r_shift  <= '0;
         r_tx     <= 1'b1;
      end else begin
         r_state  <= w_state_next;
         r_bitcnt <= w_bitcnt_next;
         r_bitidx <= w_bitidx_next;
         r_shift  <= w_shift_next;
         r_tx     <= w_tx_next;
      end
   end

   // Next-state logic: the line level for the coming cycle is decided here.
   always_comb begin
      w_state_next  = r_state;
      w_bitcnt_next = r_bitcnt;
      w_bitidx_next = r_bitidx;
      w_shift_next  = r_shift;
      w_tx_next     = r_tx;
      w_pop         = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_tx_next = 1'b1;
            if (!w_empty) begin
               w_pop         = 1'b1;
               w_shift_next  = r_mem[r_rptr];
               w_bitcnt_next = '0;
               w_state_next  = StStart;
               w_tx_next     = 1'b0;
            end
         end
         StStart: begin
            if (w_bit_end) begin
               w_bitcnt_next = '0;
               w_bitidx_next = '0;
               w_state_next  = StData;
               w_tx_next     = r_shift[0];
            end else begin
               w_bitcnt_next = r_bitcnt + 1'b1;
            end
         end
         StData: begin
            if (w_bit_end) begin
               w_bitcnt_next = '0;
               if (r_bitidx == 3'd7) begin
                  w_state_next = StStop;
                  w_tx_next    = 1'b1;
               end else begin
                  w_shift_next  = {1'b0, r_shift[7:1]};
                  w_tx_next     = r_shift[1];
                  w_bitidx_next = r_bitidx + 1'b1;
               end
            end else begin
               w_bitcnt_next = r_bitcnt + 1'b1;
            end
         end
         StStop: begin
            if (w_bit_end) begin
               w_bitcnt_next = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_shift_next = r_mem[r_rptr];
                  w_state_next = StStart;
                  w_tx_next    = 1'b0;
               end else begin
                  w_state_next = StIdle;
                  w_tx_next    = 1'b1;
               end
            end else begin
               w_bitcnt_next = r_bitcnt + 1'b1;
            end
         end
         default: begin
            w_state_next = StIdle;
            w_tx_next    = 1'b1;
         end
      endcase
   end

   assign owTx       = r_tx;
   assign owBusy     = (r_state != StIdle) || !w_empty;
   assign owFull     = w_full;
   assign owOverflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a line monitor decodes frames into a
// receive queue which is checked against bytes queued when stores are driven.
module tb_uart_tx_mmio;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned FIFO_AW = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        tx;
   logic        busy;
   logic        full;
   logic        ovf;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          sent;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      bit         ok;
   } rx_t;

   logic [7:0] exp_q[$];
   rx_t        rx_q[$];
   vec_t       vecs[7];

   uart_tx_mmio #(
      .pAddr  (32'h0000_1000),
      .pClkDiv(CLK_DIV),
      .pFifoAw(FIFO_AW)
   ) dut (
      .iwClk      (clk),
      .iwnRst     (rst_n),
      .iwWriteAddr(waddr),
      .iwWriteData(wdata),
      .iwWstrb    (wstrb),
      .owTx       (tx),
      .owBusy     (busy),
      .owFull     (full),
      .owOverflow (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: samples every cycle on the falling edge, requires each bit
   // level to be steady for CLK_DIV cycles, and pushes decoded frames.
   initial begin
      bit         mf;
      bit         ok;
      int         mc;
      int         k;
      int         pos;
      logic       lvl;
      logic [7:0] sh;
      mf = 0;
      ok = 0;
      mc = 0;
      lvl = 1'b1;
      sh = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mf = 0;
         end else begin
            if (!mf && tx === 1'b0) begin
               mf = 1;
               mc = 0;
               ok = 1;
               sh = '0;
            end
            if (mf) begin
               k   = mc / CLK_DIV;
               pos = mc % CLK_DIV;
               if (pos == 0) lvl = tx;
               else if (tx !== lvl) ok = 0;
               if (pos == CLK_DIV - 1) begin
                  if (k == 0) begin
                     if (lvl !== 1'b0) ok = 0;
                  end else if (k <= 8) begin
                     sh[k-1] = lvl;
                  end else begin
                     if (lvl !== 1'b1) ok = 0;
                     rx_q.push_back('{data: sh, ok: ok});
                     mf = 0;
                  end
               end
               mc++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One store on the bus, applied on the next rising edge; returns 1 time unit after it.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      waddr = a;
      wdata = d;
      wstrb = s;
      @(posedge clk);
      #1;
      waddr = '0;
      wdata = '0;
      wstrb = '0;
   endtask

   task automatic wait_idle(input int max, output int n);
      n = 0;
      while (busy === 1'b1 && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy !== 1'b0) check("idle_timeout", {31'b0, busy}, 32'h0);
   endtask

   task automatic drain_check(input string name);
      logic [7:0] e;
      rx_t        r;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rx_q.size() == 0) begin
            check({name, "_missing_frame"}, 32'(rx_q.size()), 32'd1);
         end else begin
            r = rx_q.pop_front();
            check({name, "_byte"}, {24'b0, r.data}, {24'b0, e});
            check({name, "_framing"}, {31'b0, r.ok}, 32'd1);
         end
      end
      check({name, "_extra_frames"}, 32'(rx_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      rx_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int t0;
      bit bad;
      vec_t v;

      vecs[0] = '{addr: 32'h0000_1000, data: 32'h0000_0055, strb: 4'b0001, sent: 1'b1};
      vecs[1] = '{addr: 32'h0000_1004, data: 32'h0000_00A3, strb: 4'b0001, sent: 1'b0};
      vecs[2] = '{addr: 32'h0000_1000, data: 32'h0000_00A3, strb: 4'b1110, sent: 1'b0};
      vecs[3] = '{addr: 32'h0000_1003, data: 32'h0000_003C, strb: 4'b0001, sent: 1'b1};
      vecs[4] = '{addr: 32'h0000_1000, data: 32'hFFFF_FF81, strb: 4'b1111, sent: 1'b1};
      vecs[5] = '{addr: 32'h0000_0000, data: 32'h0000_0012, strb: 4'b0001, sent: 1'b0};
      vecs[6] = '{addr: 32'h0000_1000, data: 32'h0000_0000, strb: 4'b0001, sent: 1'b1};

      rst_n = 1'b0;
      waddr = '0;
      wdata = '0;
      wstrb = '0;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_full", {31'b0, full}, 32'd0);
      check("reset_ovf", {31'b0, ovf}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single stores: accepted ones must produce one 40-cycle frame starting one edge later.
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         if (v.sent) exp_q.push_back(v.data[7:0]);
         store(v.addr, v.data, v.strb);
         if (v.sent) begin
            check($sformatf("vec%0d_busy_after_store", i), {31'b0, busy}, 32'd1);
            check($sformatf("vec%0d_tx_before_pop", i), {31'b0, tx}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_start_bit", i), {31'b0, tx}, 32'd0);
            wait_idle(100, n);
            check($sformatf("vec%0d_frame_cycles", i), 32'(n), 32'd40);
         end else begin
            bad = 0;
            repeat (45) begin
               if (tx !== 1'b1 || busy !== 1'b0) bad = 1;
               @(posedge clk);
               #1;
            end
            check($sformatf("vec%0d_ignored", i), {31'b0, bad}, 32'd0);
         end
         drain_check($sformatf("vec%0d", i));
      end
      check("ovf_after_singles", {31'b0, ovf}, 32'd0);

      // Three back-to-back stores: 120 cycles of line activity with no idle gap.
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      store(32'h1000, 32'h01, 4'b0001);
      t0 = cyc;
      store(32'h1000, 32'h02, 4'b0001);
      store(32'h1000, 32'h03, 4'b0001);
      wait_idle(400, n);
      check("b2b_total_cycles", 32'(cyc - t0), 32'd121);
      drain_check("b2b");

      // Six consecutive stores: one popped, four fill the FIFO, the sixth is dropped.
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 0; i < 6; i++) begin
         store(32'h1000, 32'h10 + i, 4'b0001);
         if (i == 4) begin
            check("fill_full", {31'b0, full}, 32'd1);
            check("fill_ovf_before_drop", {31'b0, ovf}, 32'd0);
         end
      end
      check("fill_ovf_after_drop", {31'b0, ovf}, 32'd1);
      wait_idle(600, n);
      check("fill_ovf_sticky", {31'b0, ovf}, 32'd1);
      drain_check("fill");

      // Store on the same edge the FSM pops from a full FIFO: still dropped.
      do_reset();
      check("ovf_cleared_by_reset", {31'b0, ovf}, 32'd0);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'h20 + 8'(i));
      store(32'h1000, 32'h20, 4'b0001);
      @(posedge clk);
      for (int i = 1; i < 5; i++) store(32'h1000, 32'h20 + i, 4'b0001);
      repeat (35) @(posedge clk);
      #1;
      check("popfull_full_before", {31'b0, full}, 32'd1);
      check("popfull_ovf_before", {31'b0, ovf}, 32'd0);
      store(32'h1000, 32'h99, 4'b0001);
      check("popfull_ovf_after", {31'b0, ovf}, 32'd1);
      check("popfull_not_full", {31'b0, full}, 32'd0);
      wait_idle(600, n);
      drain_check("popfull");

      // Asynchronous reset in the middle of a data bit with two bytes queued.
      do_reset();
      store(32'h1000, 32'hFF, 4'b0001);
      @(posedge clk);
      store(32'h1000, 32'h01, 4'b0001);
      store(32'h1000, 32'h02, 4'b0001);
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_tx", {31'b0, tx}, 32'd1);
      check("midreset_busy", {31'b0, busy}, 32'd0);
      check("midreset_full", {31'b0, full}, 32'd0);
      exp_q.delete();
      rx_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1;
      end
      check("midreset_quiet", {31'b0, bad}, 32'd0);
      drain_check("midreset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
